demux1_2_9b: RTL and testbench
==============================

# demux1_2_9b

Registered 1-to-2 demultiplexer for 9-bit Booth partial-product words with valid/ready handshakes on all three ports. A single input stream is steered, word by word, to one of two output lanes by a per-word `select` bit: `select` = 0 routes to `out1`, `select` = 1 routes to `out2`, the same in1/in2 convention the 2:1 selection muxes use. Each lane owns a 2-entry buffer, so a stalled lane does not lose data and `in_ready` never depends combinationally on any `outX_ready`. The block sits between the Booth partial-product generator and the two accumulator lanes of the FIR datapath.

## Interface
- `WIDTH`, 9: data word width in bits; must match the mux datapath width.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  WIDTH  incoming partial-product word.
- `in_select`  in  1  destination lane for `in_data`: 0 = out1, 1 = out2.
- `in_valid`  in  1  `in_data` and `in_select` are valid.
- `in_ready`  out  1  block can accept a word this cycle.
- `out1_data`  out  WIDTH  lane-1 head word.
- `out1_valid`  out  1  lane 1 holds at least one word.
- `out1_ready`  in  1  lane-1 consumer accepts the head word.
- `out2_data`, `out2_valid`, `out2_ready`: same as lane 1, for lane 2.

## Operation
- Input transfer: `in_valid && in_ready` on a rising edge. The word is written to the tail of the lane chosen by `in_select`.
- Output transfer: `outX_valid && outX_ready` on a rising edge. The head word of lane X is popped.
- Each lane is a 2-entry FIFO with a 2-bit count in the range 0..2.
  - `outX_valid` = (countX != 0).
  - `outX_data` = head entry. Its value is undefined-but-stable (held) when valid is 0.
- `in_ready` = !rst && (count1 < 2) && (count2 < 2).
  - It is a function of registered counts only, so no combinational path exists from `outX_ready` or `in_select`.
  - A full lane stalls both lanes' input intentionally; this keeps steering order simple.
- Simultaneous push and pop on the same lane: the count is unchanged, the head advances, and the new word is written behind the remaining entry.
  - With count = 1, the new word becomes head on the next cycle.
- Push to a full lane is impossible because `in_ready` is 0.
- Pop from an empty lane is ignored because valid is 0.
- Ordering is preserved within each lane. No ordering is implied across lanes.
- `in_data` and `in_select` are ignored when `in_valid` = 0 or `in_ready` = 0. The upstream must hold them stable until the transfer.
- Reset, including mid-operation: both counts go to 0 and all buffered words are discarded. `out1_valid` = `out2_valid` = 0, `out1_data` = `out2_data` = 0, and `in_ready` = 0 while `rst` is high.
- Reset is asserted asynchronously and released on the clock edge; `in_ready` rises the first cycle after `rst` falls.

## Timing
- Latency: a word accepted at edge N is visible on `outX_data`/`outX_valid` after edge N (cycle N+1). There is no bypass path.
- Throughput: 1 word per cycle sustained when the destination lanes are drained every cycle.
- `in_ready` drops the cycle after either lane's count reaches 2. It rises the cycle after that lane pops.
- Outputs are registered, except `in_ready`, which is combinational decode of registered counts plus `rst`.

## Structure
- The shared package holds `WIDTH` (9) and the lane depth constant `LANE_DEPTH` = 2. It is shared with the Booth partial-product and mux blocks.
- Sub-module `lane_buf_9b` is instantiated twice.
  - Ports: `clk`, `rst`, `push`, `push_data`, `pop`, `head`, `count`.
  - Internals: 2 entries, read/write pointers, wrap-around on pointer increment.
- The top level holds only push decode (`in_valid && in_ready` gated by `in_select`), pop decode, and `in_ready`.

## Test plan
- Reset mid-stream: fill lane 1 with 0x1A5 and lane 2 with 0x0F3, then assert `rst` asynchronously between edges. Both valids and data must go to 0 immediately. `in_ready` must be 0 during reset and 1 one cycle after release.
- Steering: with both readies held 1, send 0x001 (sel 0), 0x002 (sel 1), 0x1FF (sel 0).
  - out1 must show 0x001 then 0x1FF.
  - out2 must show 0x002.
  - Each word must appear one cycle after its acceptance.
- Backpressure/full: hold `out2_ready` = 0 and push 0x010, 0x011 to lane 2. `in_ready` must be 0 from the next cycle. A lane-1 word presented meanwhile must not be accepted. Release `out2_ready`: 0x010 and 0x011 must pop in order, and `in_ready` must return to 1.
- Simultaneous push/pop at count 1: lane 1 holds 0x055. Push 0x0AA to lane 1 while popping it. The count must stay 1 and the head must read 0x0AA next cycle.
- Wrap-around: 8 push/pop cycles through lane 2 with values 0x100–0x107 at alternating fill levels 1 and 2. The output sequence must be identical, with no drops or duplicates.
- Random soak: 10k cycles of random `in_valid`, `in_select`, and readies, checked against a reference model with two queues. There must be no loss, no reordering within a lane, and no combinational dependence of `in_ready` on the `outX_ready` inputs.

Source files
------------

// File: rtl/demux1_2_9b_pkg.sv
// Shared constants for the Booth partial-product / mux / demux datapath.
package demux1_2_9b_pkg;
  localparam int WIDTH      = 9;
  localparam int LANE_DEPTH = 2;
  localparam int CNT_W      = 2;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t LANE_FULL = cnt_t'(LANE_DEPTH);
endpackage

// File: rtl/demux1_2_9b_lane_buf.sv
// Two-entry lane FIFO with a registered head word that holds its last value when empty.
module lane_buf_9b
  import demux1_2_9b_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);
  word_t mem_r [LANE_DEPTH];
  logic  wr_ptr_r;
  logic  rd_ptr_r;
  cnt_t  count_r;
  word_t head_r;

  logic  do_push_s;
  logic  do_pop_s;
  cnt_t  count_next_s;
  word_t head_next_s;

  // next count and next head word from the qualified push/pop pair
  always_comb begin
    do_push_s    = push && (count_r != LANE_FULL);
    do_pop_s     = pop && (count_r != 2'd0);
    count_next_s = count_r;
    head_next_s  = head_r;
    case ({do_push_s, do_pop_s})
      2'b10: begin
        count_next_s = count_r + 2'd1;
        if (count_r == 2'd0) head_next_s = push_data;
        else                 head_next_s = head_r;
      end
      2'b01: begin
        count_next_s = count_r - 2'd1;
        if (count_r == LANE_FULL) head_next_s = mem_r[rd_ptr_r + 1'b1];
        else                      head_next_s = head_r;
      end
      2'b11: begin
        // only reachable at count 1: the incoming word lands directly at the head
        count_next_s = count_r;
        if (count_r == 2'd1) head_next_s = push_data;
        else                 head_next_s = mem_r[rd_ptr_r + 1'b1];
      end
      default: begin
        count_next_s = count_r;
        head_next_s  = head_r;
      end
    endcase
  end

  // storage, pointers (wrap naturally at depth 2), count and head registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_r[0] <= {WIDTH{1'b0}};
      mem_r[1] <= {WIDTH{1'b0}};
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
      head_r   <= {WIDTH{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (do_pop_s) rd_ptr_r <= rd_ptr_r + 1'b1;
      count_r <= count_next_s;
      head_r  <= head_next_s;
    end
  end

  assign head  = head_r;
  assign count = count_r;
endmodule

// File: rtl/demux1_2_9b.sv
// Registered 1-to-2 demultiplexer steering partial-product words into two buffered lanes.
module demux1_2_9b
  import demux1_2_9b_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_select,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out2_data,
  output logic             out2_valid,
  input  logic             out2_ready
);
  cnt_t count1_s;
  cnt_t count2_s;
  logic accept_s;
  logic push1_s;
  logic push2_s;
  logic pop1_s;
  logic pop2_s;

  // either full lane stalls the shared input; decoded from registered counts only
  assign in_ready = !rst && (count1_s < LANE_FULL) && (count2_s < LANE_FULL);
  assign accept_s = in_valid && in_ready;
  assign push1_s  = accept_s && !in_select;
  assign push2_s  = accept_s && in_select;

  assign out1_valid = (count1_s != 2'd0);
  assign out2_valid = (count2_s != 2'd0);
  assign pop1_s     = out1_valid && out1_ready;
  assign pop2_s     = out2_valid && out2_ready;

  lane_buf_9b u_lane1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push1_s),
    .push_data (in_data),
    .pop       (pop1_s),
    .head      (out1_data),
    .count     (count1_s)
  );

  lane_buf_9b u_lane2 (
    .clk       (clk),
    .rst       (rst),
    .push      (push2_s),
    .push_data (in_data),
    .pop       (pop2_s),
    .head      (out2_data),
    .count     (count2_s)
  );
endmodule

// File: tb/tb_demux1_2_9b.sv
// Self-checking bench: directed scenarios plus random soak against a two-queue reference model.
module tb_demux1_2_9b;
  logic       clk;
  logic       rst;
  logic [8:0] in_data;
  logic       in_select;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] out1_data;
  logic       out1_valid;
  logic       out1_ready;
  logic [8:0] out2_data;
  logic       out2_valid;
  logic       out2_ready;

  int n_checks;
  int n_errors;

  logic [8:0] q1[$];
  logic [8:0] q2[$];
  logic [8:0] last1;
  logic [8:0] last2;
  logic [8:0] obs2[$];

  demux1_2_9b dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_select  (in_select),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out2_data  (out2_data),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic exp_ready();
    return !rst && (q1.size() < 2) && (q2.size() < 2);
  endfunction

  task automatic compare_all();
    check_eq("in_ready",   32'(in_ready),   32'(exp_ready()));
    check_eq("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
    check_eq("out1_data",  32'(out1_data),  32'(last1));
    check_eq("out2_valid", 32'(out2_valid), 32'(q2.size() != 0));
    check_eq("out2_data",  32'(out2_data),  32'(last2));
  endtask

  task automatic clear_model();
    q1.delete();
    q2.delete();
    last1 = 9'h000;
    last2 = 9'h000;
  endtask

  // one clock cycle: check at negedge, drive, probe in_ready isolation, update model at posedge
  task automatic step(input logic v, input logic s, input logic [8:0] d,
                      input logic r1, input logic r2);
    logic acc;
    @(negedge clk);
    compare_all();
    in_valid = v; in_select = s; in_data = d; out1_ready = r1; out2_ready = r2;
    if (out2_valid && r2) obs2.push_back(out2_data);
    #1;
    out1_ready = !r1; out2_ready = !r2; in_select = !s;
    #1;
    check_eq("ready_isolation", 32'(in_ready), 32'(exp_ready()));
    out1_ready = r1; out2_ready = r2; in_select = s;
    @(posedge clk);
    acc = v && exp_ready();
    if (r1 && q1.size() != 0) void'(q1.pop_front());
    if (r2 && q2.size() != 0) void'(q2.pop_front());
    if (acc) begin
      if (s) q2.push_back(d);
      else   q1.push_back(d);
    end
    if (q1.size() != 0) last1 = q1[0];
    if (q2.size() != 0) last2 = q2[0];
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b1; in_valid = 1'b0; in_select = 1'b0; in_data = 9'h000;
    out1_ready = 1'b0; out2_ready = 1'b0;
    clear_model();

    // power-on reset state
    @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out1_valid", 32'(out1_valid), 32'd0);
    check_eq("rst_out2_valid", 32'(out2_valid), 32'd0);
    check_eq("rst_out1_data", 32'(out1_data), 32'd0);
    check_eq("rst_out2_data", 32'(out2_data), 32'd0);
    #1 rst = 1'b0;

    // steering with both readies high
    step(1'b1, 1'b0, 9'h001, 1'b1, 1'b1);
    step(1'b1, 1'b1, 9'h002, 1'b1, 1'b1);
    step(1'b1, 1'b0, 9'h1FF, 1'b1, 1'b1);
    step(1'b0, 1'b0, 9'h000, 1'b1, 1'b1);
    check_eq("steer_out1_second", 32'(out1_data), 32'h1FF);
    step(1'b0, 1'b0, 9'h000, 1'b1, 1'b1);

    // backpressure on lane 2 blocks lane 1 as well
    step(1'b1, 1'b1, 9'h010, 1'b1, 1'b0);
    step(1'b1, 1'b1, 9'h011, 1'b1, 1'b0);
    step(1'b1, 1'b0, 9'h0EE, 1'b1, 1'b0);
    check_eq("bp_in_ready_low", 32'(in_ready), 32'd0);
    step(1'b1, 1'b0, 9'h0EE, 1'b1, 1'b0);
    check_eq("bp_lane1_empty", 32'(out1_valid), 32'd0);
    step(1'b1, 1'b0, 9'h0EE, 1'b1, 1'b1);
    step(1'b1, 1'b0, 9'h0EE, 1'b1, 1'b1);
    step(1'b0, 1'b0, 9'h000, 1'b1, 1'b1);
    step(1'b0, 1'b0, 9'h000, 1'b1, 1'b1);

    // simultaneous push/pop at count 1
    step(1'b1, 1'b0, 9'h055, 1'b0, 1'b0);
    step(1'b1, 1'b0, 9'h0AA, 1'b1, 1'b0);
    @(negedge clk);
    check_eq("pp_head", 32'(out1_data), 32'h0AA);
    check_eq("pp_valid", 32'(out1_valid), 32'd1);
    step(1'b0, 1'b0, 9'h000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 9'h000, 1'b1, 1'b1);

    // wrap-around through lane 2 alternating fill levels 1 and 2
    obs2.delete();
    step(1'b1, 1'b1, 9'h100, 1'b1, 1'b0);
    for (int i = 1; i < 8; i++) begin
      step(1'b1, 1'b1, 9'(9'h100 + i), 1'b1, 1'b0);
      step(1'b0, 1'b1, 9'h000, 1'b1, 1'b1);
    end
    step(1'b0, 1'b1, 9'h000, 1'b1, 1'b1);
    step(1'b0, 1'b1, 9'h000, 1'b1, 1'b1);
    check_eq("wrap_count", 32'(obs2.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < obs2.size()) check_eq("wrap_seq", 32'(obs2[i]), 32'(9'h100 + i));
    end

    // reset mid-stream
    step(1'b1, 1'b0, 9'h1A5, 1'b0, 1'b0);
    step(1'b1, 1'b1, 9'h0F3, 1'b0, 1'b0);
    @(negedge clk);
    compare_all();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_out1_valid", 32'(out1_valid), 32'd0);
    check_eq("mid_rst_out2_valid", 32'(out2_valid), 32'd0);
    check_eq("mid_rst_out1_data", 32'(out1_data), 32'd0);
    check_eq("mid_rst_out2_data", 32'(out2_data), 32'd0);
    check_eq("mid_rst_in_ready", 32'(in_ready), 32'd0);
    clear_model();
    @(posedge clk);
    #1;
    check_eq("mid_rst_hold_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    step(1'b0, 1'b0, 9'h000, 1'b1, 1'b1);

    // random soak
    for (int n = 0; n < 10000; n++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 9'($urandom()),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
    end
    step(1'b0, 1'b0, 9'h000, 1'b1, 1'b1);
    step(1'b0, 1'b0, 9'h000, 1'b1, 1'b1);
    step(1'b0, 1'b0, 9'h000, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
